// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: 2-bit branch counter encodings,
// instruction size and the saturating counter update rule.
package fetch_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    localparam cnt_e        CNT_RESET  = CNT_WNT;
    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic cnt_e cnt_update(input cnt_e cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt_e'(cnt + 2'd1);
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt_e'(cnt - 2'd1);
    endfunction

endpackage

// File: rtl/bht_counter_array.sv
// Branch history table: array of saturating 2-bit counters with one
// combinational read port and one synchronous training port.
module bht_counter_array
    import fetch_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    cnt_e cnt_q [ENTRIES];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // reader in the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_RESET;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= cnt_update(cnt_q[wr_idx_i], wr_taken_i);
        end
    end

    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/fetch_predict_unit.sv
// Fetch front end: PC register with redirect/stall/predict next-PC selection.
// Define FETCH_BHT_EN to build the BHT + BTB predictor; otherwise static not-taken.
module fetch_predict_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_br_pc,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    output logic [31:0] imem_addr,
    output logic [31:0] if_pc,
    output logic        if_predicted_bit,
    output logic [31:0] if_pred_target
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

`ifdef FETCH_BHT_EN
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = 32 - BTB_IW - 2;

    logic [1:0]        bht_cnt;
    logic              btb_wr;
    logic [BTB_IW-1:0] btb_rd_idx;
    logic [BTB_IW-1:0] btb_wr_idx;
    logic [TAG_W-1:0]  btb_rd_tag;
    logic [TAG_W-1:0]  btb_wr_tag;
    logic              unused_br;

    logic              btb_valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q    [BTB_ENTRIES];
    logic [31:0]       btb_target_q [BTB_ENTRIES];

    bht_counter_array #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (pc_q[BHT_IW+1:2]),
        .rd_cnt_o   (bht_cnt),
        .wr_en_i    (ex_br_valid),
        .wr_idx_i   (ex_br_pc[BHT_IW+1:2]),
        .wr_taken_i (ex_br_taken)
    );

    assign btb_rd_idx = pc_q[BTB_IW+1:2];
    assign btb_rd_tag = pc_q[31:BTB_IW+2];
    assign btb_wr_idx = ex_br_pc[BTB_IW+1:2];
    assign btb_wr_tag = ex_br_pc[31:BTB_IW+2];
    assign btb_wr     = ex_br_valid && ex_br_taken;
    assign unused_br  = ^ex_br_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else if (btb_wr) begin
            btb_valid_q[btb_wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target payload is deliberately not reset; the valid bit
    // alone decides whether an entry can produce a hit.
    always_ff @(posedge clk) begin
        if (btb_wr && !rst) begin
            btb_tag_q[btb_wr_idx]    <= btb_wr_tag;
            btb_target_q[btb_wr_idx] <= ex_br_target;
        end
    end

    assign if_predicted_bit = bht_cnt[1] && btb_valid_q[btb_rd_idx] &&
                              (btb_tag_q[btb_rd_idx] == btb_rd_tag);
    assign if_pred_target   = btb_target_q[btb_rd_idx];
`else
    logic unused_br;

    assign unused_br        = ^{ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target};
    assign if_predicted_bit = 1'b0;
    assign if_pred_target   = 32'h0000_0000;
`endif

    // NOTE: pc_d gets a default before any branch so no path infers a latch.
    always_comb begin
        pc_d = pc_q + INST_BYTES;
        if (ex_redirect) begin
            pc_d = ex_redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (if_predicted_bit) begin
            pc_d = if_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign if_pc     = pc_q;
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Scoreboard bench for fetch_predict_unit: directed fetch/stall/redirect/training
// sequences followed by random traffic, checked against a table-level model.
module tb_fetch_predict_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          BHT_N    = 64;
    localparam int          BTB_N    = 16;
    localparam int          BTB_IW   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic        if_predicted_bit;
    logic [31:0] if_pred_target;

    fetch_predict_unit #(
        .RESET_PC    (RESET_PC),
        .BHT_ENTRIES (BHT_N),
        .BTB_ENTRIES (BTB_N)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_redirect      (ex_redirect),
        .ex_redirect_pc   (ex_redirect_pc),
        .ex_br_valid      (ex_br_valid),
        .ex_br_pc         (ex_br_pc),
        .ex_br_taken      (ex_br_taken),
        .ex_br_target     (ex_br_target),
        .imem_addr        (imem_addr),
        .if_pc            (if_pc),
        .if_predicted_bit (if_predicted_bit),
        .if_pred_target   (if_pred_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    // Reference model: counters as plain integers, BTB as arrays keyed by index.
    logic [31:0] m_pc;
    int          m_cnt [BHT_N];
    bit          m_val [BTB_N];
    logic [31:0] m_tag [BTB_N];
    logic [31:0] m_tgt [BTB_N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bht_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(BHT_N));
    endfunction

    function automatic int btb_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(BTB_N));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
`ifdef FETCH_BHT_EN
        int ti = btb_idx(pc);
        return (m_cnt[bht_idx(pc)] >= 2) && m_val[ti] && (m_tag[ti] == (pc >> (BTB_IW + 2)));
`else
        return (pc === 32'hxxxx_xxxx);
`endif
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC;
        for (int i = 0; i < BHT_N; i++) m_cnt[i] = 1;
        for (int i = 0; i < BTB_N; i++) m_val[i] = 1'b0;
    endtask

    // One clock: drive inputs, record expected outputs of this cycle, advance model.
    task automatic cycle(input logic r, input logic s, input logic red, input logic [31:0] rpc,
                         input logic bv, input logic [31:0] bpc, input logic bt,
                         input logic [31:0] btgt);
        exp_t e;
        rst = r; stall = s; ex_redirect = red; ex_redirect_pc = rpc;
        ex_br_valid = bv; ex_br_pc = bpc; ex_br_taken = bt; ex_br_target = btgt;
        e.pc   = m_pc;
        e.pred = m_hit(m_pc);
        e.tgt  = e.pred ? m_tgt[btb_idx(m_pc)] : 32'h0;
        sb_q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (red)         m_pc = rpc;
            else if (!s)     m_pc = e.pred ? e.tgt : m_pc + 32'd4;
`ifdef FETCH_BHT_EN
            if (bv) begin
                int bi = bht_idx(bpc);
                m_cnt[bi] = bt ? ((m_cnt[bi] < 3) ? m_cnt[bi] + 1 : 3)
                               : ((m_cnt[bi] > 0) ? m_cnt[bi] - 1 : 0);
                if (bt) begin
                    m_val[btb_idx(bpc)] = 1'b1;
                    m_tag[btb_idx(bpc)] = bpc >> (BTB_IW + 2);
                    m_tgt[btb_idx(bpc)] = btgt;
                end
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        cycle(0, 0, 0, 0, 1, pc, taken, tgt);
    endtask

    task automatic redirect(input logic [31:0] pc);
        cycle(0, 0, 1, pc, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel = $urandom_range(0, 15);
        if (sel == 0) return {$urandom()} & 32'hFFFF_FFFC;
        if (sel < 4)  return (32'($urandom_range(0, 63)) << 2) | 32'h400;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    // Monitor: outputs are valid every cycle once out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got no expectation at t=%0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("if_pc", if_pc, mon_e.pc);
                    check("imem_addr", imem_addr, mon_e.pc);
                    check("if_predicted_bit", 32'(if_predicted_bit), 32'(mon_e.pred));
`ifdef FETCH_BHT_EN
                    if (mon_e.pred) check("if_pred_target", if_pred_target, mon_e.tgt);
`else
                    check("if_pred_target", if_pred_target, 32'h0);
`endif
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
        ex_br_valid = 1'b0; ex_br_pc = '0; ex_br_taken = 1'b0; ex_br_target = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;

        // Sequential fetch, then stall at 0x10 and release.
        idle(4);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Redirect wins over stall.
        cycle(0, 1, 1, 32'h200, 0, 0, 0, 0);
        idle(1);

        // Single taken update makes 0x40 predicted taken to 0x100.
        train(32'h40, 1, 32'h100);
        redirect(32'h30);
        idle(6);

        // Two not-taken updates bring the counter back to not-taken.
        train(32'h40, 0, 0);
        train(32'h40, 0, 0);
        redirect(32'h40);
        idle(2);

        // Saturate, back off one step, still predicted taken.
        repeat (5) train(32'h40, 1, 32'h100);
        train(32'h40, 0, 0);
        redirect(32'h40);
        idle(2);

        // Alias with a different tag is not a hit.
        redirect(32'h440);
        idle(2);

        // PC wraps modulo 2^32.
        redirect(32'hFFFF_FFFC);
        idle(2);

        // Reset discards same-cycle training.
        cycle(1, 0, 0, 0, 1, 32'h8, 1, 32'h300);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r   = ($urandom_range(0, 399) == 0);
            logic        s   = ($urandom_range(0, 7) == 0);
            logic        red = ($urandom_range(0, 11) == 0);
            logic        bv  = ($urandom_range(0, 2) == 0);
            logic        bt  = ($urandom_range(0, 3) != 0);
            logic [31:0] rpc = rand_addr();
            logic [31:0] bpc = rand_addr();
            logic [31:0] tgt = rand_addr();
            cycle(r, s, red, rpc, bv, bpc, bt, tgt);
        end

        mon_en = 1'b0;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
